// File: rtl/add8u_share_arb_pkg.sv
// Shared constants for the shared-adder arbiter: operand/sum widths and the
// arbitration pointer reset value.
package add8u_share_arb_pkg;

    localparam int unsigned OpW  = 8;
    localparam int unsigned SumW = 9;

    // Pointer starts at the last requester so requester 0 wins first after reset.
    function automatic int unsigned ptr_rst_val(input int unsigned n_req);
        return n_req - 1;
    endfunction

endpackage

// File: rtl/add8u_share_arb_core.sv
// Exact 8-bit unsigned adder; kept separate so an approximate variant with the
// same ports can be dropped in.
module add8u_core
    import add8u_share_arb_pkg::*;
(
    input  logic [OpW-1:0]  i_a,
    input  logic [OpW-1:0]  i_b,
    output logic [SumW-1:0] o_sum
);

    assign o_sum = {1'b0, i_a} + {1'b0, i_b};

endmodule

// File: rtl/add8u_share_arb.sv
// N_REQ requesters share one adder through a round-robin arbiter feeding a
// two-stage valid/ready pipeline (S1: operands+tag, S2: sum+tag).
module add8u_share_arb
    import add8u_share_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [N_REQ-1:0]       i_req_valid,
    input  logic [OpW*N_REQ-1:0]   i_req_a,
    input  logic [OpW*N_REQ-1:0]   i_req_b,
    output logic [N_REQ-1:0]       o_req_ready,
    output logic                   o_res_valid,
    input  logic                   i_res_ready,
    output logic [SumW-1:0]        o_res_sum,
    output logic [ID_W-1:0]        o_res_id,
    output logic                   o_busy
);

    logic            r_s1_valid;
    logic [OpW-1:0]  r_s1_a;
    logic [OpW-1:0]  r_s1_b;
    logic [ID_W-1:0] r_s1_id;
    logic            r_s2_valid;
    logic [SumW-1:0] r_s2_sum;
    logic [ID_W-1:0] r_s2_id;
    logic [ID_W-1:0] r_ptr;

    logic            w_s2_ready;
    logic            w_s1_adv;
    logic            w_s1_ready;
    logic            w_gnt_found;
    logic [ID_W-1:0] w_gnt_id;
    int unsigned     w_cand;
    logic            w_accept;
    logic [OpW-1:0]  w_sel_a;
    logic [OpW-1:0]  w_sel_b;
    logic [SumW-1:0] w_sum;

    assign w_s2_ready = !r_s2_valid || i_res_ready;
    assign w_s1_adv   = r_s1_valid && w_s2_ready;
    assign w_s1_ready = (!r_s1_valid || w_s1_adv) && !i_rst;

    // Round-robin search starting just after the last granted index.
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_id    = '0;
        w_cand      = 0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            w_cand = (32'(r_ptr) + k) % N_REQ;
            if (!w_gnt_found && i_req_valid[w_cand[ID_W-1:0]]) begin
                w_gnt_found = 1'b1;
                w_gnt_id    = w_cand[ID_W-1:0];
            end
        end
    end

    assign w_accept = w_gnt_found && w_s1_ready;

    always_comb begin
        o_req_ready = '0;
        if (w_accept) begin
            o_req_ready[w_gnt_id] = 1'b1;
        end
    end

    assign w_sel_a = i_req_a[w_gnt_id*OpW +: OpW];
    assign w_sel_b = i_req_b[w_gnt_id*OpW +: OpW];

    add8u_core u_core (
        .i_a   (r_s1_a),
        .i_b   (r_s1_b),
        .o_sum (w_sum)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_id    <= '0;
            r_s2_valid <= 1'b0;
            r_s2_sum   <= '0;
            r_s2_id    <= '0;
            r_ptr      <= ID_W'(ptr_rst_val(N_REQ));
        end else begin
            if (w_s1_adv) begin
                r_s2_valid <= 1'b1;
                r_s2_sum   <= w_sum;
                r_s2_id    <= r_s1_id;
            end else if (i_res_ready) begin
                r_s2_valid <= 1'b0;
            end

            if (w_accept) begin
                r_s1_valid <= 1'b1;
                r_s1_a     <= w_sel_a;
                r_s1_b     <= w_sel_b;
                r_s1_id    <= w_gnt_id;
                r_ptr      <= w_gnt_id;
            end else if (w_s1_adv) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    assign o_res_valid = r_s2_valid;
    assign o_res_sum   = r_s2_sum;
    assign o_res_id    = r_s2_id;
    assign o_busy      = r_s1_valid || r_s2_valid;

endmodule

// File: tb/tb_add8u_share_arb.sv
// Self-checking bench: directed scenarios plus random traffic compared against
// a queue-based model of the shared adder pipeline.
module tb_add8u_share_arb;

    localparam int N    = 4;
    localparam int ID_W = 2;

    logic             clk = 1'b0;
    logic             i_rst;
    logic [N-1:0]     i_req_valid;
    logic [8*N-1:0]   i_req_a;
    logic [8*N-1:0]   i_req_b;
    logic [N-1:0]     o_req_ready;
    logic             o_res_valid;
    logic             i_res_ready;
    logic [8:0]       o_res_sum;
    logic [ID_W-1:0]  o_res_id;
    logic             o_busy;

    always #5 clk = ~clk;

    add8u_share_arb #(
        .N_REQ (N),
        .ID_W  (ID_W)
    ) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_req_valid (i_req_valid),
        .i_req_a     (i_req_a),
        .i_req_b     (i_req_b),
        .o_req_ready (o_req_ready),
        .o_res_valid (o_res_valid),
        .i_res_ready (i_res_ready),
        .o_res_sum   (o_res_sum),
        .o_res_id    (o_res_id),
        .o_busy      (o_busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Model: in-flight results in acceptance order; age counts edges since accept.
    typedef struct {
        int sum;
        int id;
        int age;
    } item_t;

    item_t q[$];
    bit    pend[N];
    int    opa[N];
    int    opb[N];
    int    wait_cnt[N];
    int    mptr;
    bit    rst_v, rdy_v, keep_all, rnd_raise;
    int    dut_gnt;
    logic [8:0] saved_sum;

    task automatic step();
        int  n;
        bit  head_vis, found, acc, consume;
        int  g, c;
        logic [N-1:0] exp_rdy;
        item_t it;

        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (!pend[i] && (keep_all || (rnd_raise && $urandom_range(0, 2) == 0))) begin
                pend[i] = 1'b1;
                opa[i]  = int'($urandom_range(0, 255));
                opb[i]  = int'($urandom_range(0, 255));
            end
        end
        i_rst       = rst_v;
        i_res_ready = rdy_v;
        for (int i = 0; i < N; i++) begin
            i_req_valid[i]     = pend[i];
            i_req_a[8*i +: 8]  = 8'(opa[i]);
            i_req_b[8*i +: 8]  = 8'(opb[i]);
        end
        #1;

        n        = q.size();
        head_vis = (n > 0) && (q[0].age >= 1);
        found    = 1'b0;
        g        = 0;
        if (!rst_v) begin
            for (int k = 1; k <= N; k++) begin
                c = (mptr + k) % N;
                if (!found && pend[c]) begin
                    found = 1'b1;
                    g     = c;
                end
            end
        end
        // Pipeline holds at most two; when full, room opens only if the output drains.
        acc     = found && ((n < 2) || rdy_v);
        exp_rdy = '0;
        if (acc) exp_rdy[g] = 1'b1;

        dut_gnt = -1;
        for (int i = 0; i < N; i++) if (o_req_ready[i]) dut_gnt = i;

        check_eq("req_ready", 32'(o_req_ready), 32'(exp_rdy));
        check_eq("res_valid", 32'(o_res_valid), 32'(head_vis));
        check_eq("busy", 32'(o_busy), 32'(n > 0));
        if (head_vis) begin
            check_eq("res_sum", 32'(o_res_sum), 32'(q[0].sum));
            check_eq("res_id", 32'(o_res_id), 32'(q[0].id));
        end
        consume = head_vis && rdy_v && !rst_v;

        @(posedge clk);
        if (rst_v) begin
            q.delete();
            mptr = N - 1;
            for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        end else begin
            foreach (q[i]) q[i].age++;
            if (consume) void'(q.pop_front());
            if (acc) begin
                check_eq("starve", 32'(wait_cnt[g] < N), 32'd1);
                for (int i = 0; i < N; i++) if (pend[i] && i != g) wait_cnt[i]++;
                wait_cnt[g] = 0;
                it.sum = opa[g] + opb[g];
                it.id  = g;
                it.age = 0;
                q.push_back(it);
                mptr    = g;
                pend[g] = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        rst_v = 1'b1;
        step();
        rst_v = 1'b0;
    endtask

    initial begin
        rst_v = 1'b1; rdy_v = 1'b1; keep_all = 1'b0; rnd_raise = 1'b0;
        mptr = N - 1;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0; opa[i] = 0; opb[i] = 0; wait_cnt[i] = 0;
        end
        i_rst = 1'b1; i_res_ready = 1'b1; i_req_valid = '0; i_req_a = '0; i_req_b = '0;
        repeat (2) @(posedge clk);

        // Reset state
        do_reset();
        #1;
        check_eq("rst_sum", 32'(o_res_sum), 32'd0);
        check_eq("rst_id", 32'(o_res_id), 32'd0);
        check_eq("rst_valid", 32'(o_res_valid), 32'd0);

        // Single request from requester 2, two-cycle latency
        pend[2] = 1'b1; opa[2] = 3; opb[2] = 5;
        step();
        check_eq("gnt_r2", 32'(dut_gnt), 32'd2);
        step();
        #1;
        check_eq("lat_valid", 32'(o_res_valid), 32'd1);
        check_eq("lat_sum", 32'(o_res_sum), 32'd8);
        check_eq("lat_id", 32'(o_res_id), 32'd2);
        repeat (2) step();

        // Carry-out and zero operands
        pend[0] = 1'b1; opa[0] = 255; opb[0] = 255;
        repeat (3) step();
        pend[0] = 1'b1; opa[0] = 0; opb[0] = 0;
        repeat (3) step();

        // All requesters continuously valid from reset: strict rotation
        do_reset();
        keep_all = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            check_eq("rr_order", 32'(dut_gnt), 32'(k % N));
        end
        keep_all = 1'b0;
        repeat (4) step();

        // Backpressure: three stalled cycles, then drain six results in order
        rdy_v = 1'b0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b1; opa[i] = 10 * i + 7; opb[i] = 200 - i;
        end
        step();
        step();
        #1;
        saved_sum = o_res_sum;
        step();
        #1;
        check_eq("bp_ready", 32'(o_req_ready), 32'd0);
        check_eq("bp_stable", 32'(o_res_sum), 32'(saved_sum));
        rdy_v = 1'b1;
        pend[0] = 1'b1; opa[0] = 128; opb[0] = 128;
        pend[1] = 1'b1; opa[1] = 1;   opb[1] = 254;
        repeat (10) step();

        // Reset with both stages full
        rdy_v = 1'b0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b1; opa[i] = 50 + i; opb[i] = 60 + i;
        end
        repeat (3) step();
        do_reset();
        #1;
        check_eq("mid_rst_valid", 32'(o_res_valid), 32'd0);
        check_eq("mid_rst_busy", 32'(o_busy), 32'd0);
        rdy_v = 1'b1;
        for (int i = 0; i < N; i++) pend[i] = 1'b1;
        step();
        check_eq("post_rst_gnt", 32'(dut_gnt), 32'd0);
        repeat (8) step();

        // Random traffic with random backpressure and occasional reset
        rnd_raise = 1'b1;
        for (int k = 0; k < 20000; k++) begin
            rdy_v = ($urandom_range(0, 3) != 0);
            rst_v = ($urandom_range(0, 499) == 0);
            step();
        end
        rst_v = 1'b0; rnd_raise = 1'b0; rdy_v = 1'b1;
        repeat (12) step();
        check_eq("drained", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
